// File: rtl/adda_sequencer.sv
// Sequencer for the ULX3S 8-bit AD/DA add-on. It divides i_clk down to the shared converter
// clock, captures and strobes ADC samples, and selects the DAC source once per converter period.
module adda_sequencer #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned ADC_LATENCY = 5,
    parameter logic [7:0]  MIDSCALE    = 8'h80
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic [1:0] i_mode,
    input  logic [7:0] i_const,
    input  logic [7:0] i_ad_data,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_adclk,
    output logic       o_daclk,
    output logic [7:0] o_da_data,
    output logic [7:0] o_sample,
    output logic       o_sample_valid,
    output logic       o_underrun,
    input  logic       i_clr_underrun,
    output logic       o_busy
);

    localparam int unsigned HALF = CLK_DIV / 2;
    localparam int unsigned PW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned WW   = (ADC_LATENCY > 1) ? $clog2(ADC_LATENCY) : 1;

    localparam logic [PW-1:0] PH_LAST   = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_UPD    = PW'(HALF - 1);
    localparam logic [PW-1:0] PH_HALF   = PW'(HALF);
    localparam logic [WW-1:0] WARM_LAST = WW'(ADC_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        RUN
    } state_t;

    state_t        state;
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_nxt;
    logic [WW-1:0] warm_cnt;
    logic          have_sample;
    logic          last;
    logic          upd;
    logic          underrun_set;

    always_comb begin
        last         = (phase == PH_LAST);
        upd          = (phase == PH_UPD);
        phase_nxt    = last ? '0 : phase + 1'b1;
        // A stream slot is missed when no handshake completes at the DAC update edge.
        underrun_set = (state != IDLE) && upd && (i_mode == 2'd1) &&
                       !(o_tx_ready && i_tx_valid);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= IDLE;
            phase          <= '0;
            warm_cnt       <= '0;
            have_sample    <= 1'b0;
            o_adclk        <= 1'b0;
            o_daclk        <= 1'b0;
            o_da_data      <= MIDSCALE;
            o_sample       <= '0;
            o_sample_valid <= 1'b0;
            o_tx_ready     <= 1'b0;
            o_underrun     <= 1'b0;
            o_busy         <= 1'b0;
        end else begin
            o_sample_valid <= 1'b0;
            o_underrun     <= underrun_set | (o_underrun & ~i_clr_underrun);

            case (state)
                IDLE: begin
                    phase       <= '0;
                    warm_cnt    <= '0;
                    have_sample <= 1'b0;
                    o_adclk     <= 1'b0;
                    o_daclk     <= 1'b0;
                    o_tx_ready  <= 1'b0;
                    if (i_enable) begin
                        state      <= WARMUP;
                        o_adclk    <= 1'b1;
                        o_daclk    <= 1'b1;
                        o_busy     <= 1'b1;
                        o_tx_ready <= (PH_UPD == '0) && (i_mode == 2'd1);
                    end
                end

                WARMUP, RUN: begin
                    phase      <= phase_nxt;
                    o_adclk    <= (phase_nxt < PH_HALF);
                    o_daclk    <= (phase_nxt < PH_HALF);
                    o_tx_ready <= (phase_nxt == PH_UPD) && (i_mode == 2'd1);

                    if (upd) begin
                        case (i_mode)
                            2'd0: o_da_data <= have_sample ? o_sample : MIDSCALE;
                            2'd1: if (o_tx_ready && i_tx_valid) o_da_data <= i_tx_data;
                            2'd2: o_da_data <= i_const;
                            default: o_da_data <= MIDSCALE;
                        endcase
                    end

                    if (last) begin
                        if (state == RUN) begin
                            o_sample       <= i_ad_data;
                            o_sample_valid <= 1'b1;
                            have_sample    <= 1'b1;
                        end else if (warm_cnt == WARM_LAST) begin
                            state <= RUN;
                        end else begin
                            warm_cnt <= warm_cnt + 1'b1;
                        end

                        // Disable is only honoured here; the final capture above still stands.
                        if (!i_enable) begin
                            state       <= IDLE;
                            phase       <= '0;
                            warm_cnt    <= '0;
                            have_sample <= 1'b0;
                            o_adclk     <= 1'b0;
                            o_daclk     <= 1'b0;
                            o_tx_ready  <= 1'b0;
                            o_busy      <= 1'b0;
                            o_da_data   <= MIDSCALE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adda_sequencer.sv
// Bench for adda_sequencer: a vector table, directed corner sequences, and a randomized run,
// all checked against a cycle-count reference model of the converter timing.
module tb_adda_sequencer;

    localparam int DIV  = 4;
    localparam int LAT  = 2;
    localparam int HALF = DIV / 2;
    localparam logic [7:0] MID = 8'h80;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'd2;
    logic [7:0] cst = 8'h33;
    logic [7:0] ad = 8'h10;
    logic [7:0] txd = 8'h00;
    logic       txv = 1'b0;
    logic       clr = 1'b0;

    logic       tx_ready, adclk, daclk, sample_valid, underrun, busy;
    logic [7:0] da_data, sample;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;

    adda_sequencer #(
        .CLK_DIV(DIV),
        .ADC_LATENCY(LAT),
        .MIDSCALE(MID)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_enable(en),
        .i_mode(mode),
        .i_const(cst),
        .i_ad_data(ad),
        .i_tx_data(txd),
        .i_tx_valid(txv),
        .o_tx_ready(tx_ready),
        .o_adclk(adclk),
        .o_daclk(daclk),
        .o_da_data(da_data),
        .o_sample(sample),
        .o_sample_valid(sample_valid),
        .o_underrun(underrun),
        .i_clr_underrun(clr),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: time since enable, in i_clk cycles, drives everything.
    bit         m_on = 0, m_valid = 0, m_ready = 0, m_und = 0, m_have = 0;
    int         m_t = 0;
    logic [7:0] m_da = MID, m_sample = 8'h00;

    always @(posedge clk) begin
        bit newund;
        int ph;
        newund = 0;
        if (rst) begin
            m_on = 0; m_t = 0; m_da = MID; m_sample = 8'h00;
            m_valid = 0; m_ready = 0; m_und = 0; m_have = 0;
        end else begin
            m_valid = 0;
            if (!m_on) begin
                if (en) begin
                    m_on = 1; m_t = 0;
                    m_ready = (HALF == 1) && (mode == 2'd1);
                end
            end else begin
                ph = m_t % DIV;
                if (ph == HALF - 1) begin
                    case (mode)
                        2'd0: m_da = m_have ? m_sample : MID;
                        2'd1: if (m_ready && txv) m_da = txd; else newund = 1;
                        2'd2: m_da = cst;
                        default: m_da = MID;
                    endcase
                end
                if (ph == DIV - 1 && (m_t / DIV) >= LAT) begin
                    m_sample = ad; m_valid = 1; m_have = 1;
                end
                m_t++;
                if (ph == DIV - 1 && !en) begin
                    m_on = 0; m_t = 0; m_da = MID; m_have = 0;
                end
                m_ready = m_on && ((m_t % DIV) == HALF - 1) && (mode == 2'd1);
            end
            m_und = newund | (m_und & ~clr);
        end
    end

    always @(negedge clk) begin
        logic [21:0] act, exp;
        logic        m_clk;
        if (chk_on) begin
            m_clk = m_on && ((m_t % DIV) < HALF);
            act = {adclk, daclk, da_data, sample, sample_valid, tx_ready, underrun, busy};
            exp = {m_clk, m_clk, m_da, m_sample, m_valid, m_ready, m_und, m_on};
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL model t=%0t: got %h expected %h (adclk,daclk,da,sample,valid,ready,und,busy)",
                         $time, act, exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic goto_ph(input int p);
        int k = 0;
        while (!(m_on && (m_t % DIV) == p) && k < 2 * DIV) begin
            step();
            k++;
        end
        chk("goto_phase_timeout", 8'(k < 2 * DIV), 8'h01);
    endtask

    typedef struct {
        logic       rst, en;
        logic [1:0] mode;
        logic [7:0] ad;
        logic       adclk;
        logic [7:0] da;
        logic       valid;
        logic [7:0] sample;
        logic       busy;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic e, input logic [1:0] m, input logic [7:0] a,
                                input logic c, input logic [7:0] d, input logic v,
                                input logic [7:0] s, input logic b);
        vec_t x;
        x.rst = r; x.en = e; x.mode = m; x.ad = a;
        x.adclk = c; x.da = d; x.valid = v; x.sample = s; x.busy = b;
        return x;
    endfunction

    vec_t tbl[$];

    initial begin
        int cnt;
        // rst en mode ad | adclk da valid sample busy   (row k>=4 leaves enable-relative cycle k-4)
        tbl.push_back(mk(1, 0, 2, 8'h10, 0, 8'h80, 0, 8'h00, 0));
        tbl.push_back(mk(1, 0, 2, 8'h10, 0, 8'h80, 0, 8'h00, 0));
        tbl.push_back(mk(1, 0, 2, 8'h10, 0, 8'h80, 0, 8'h00, 0));
        tbl.push_back(mk(0, 1, 2, 8'h10, 1, 8'h80, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 2, 8'h10, 1, 8'h80, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 2, 8'h10, 0, 8'h33, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 2, 8'h10, 0, 8'h33, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 2, 8'h10, 1, 8'h33, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 2, 8'h11, 1, 8'h33, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 2, 8'h11, 0, 8'h33, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 2, 8'h11, 0, 8'h33, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 2, 8'h11, 1, 8'h33, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 2, 8'h12, 1, 8'h33, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 0, 8'h12, 0, 8'h80, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 0, 8'h12, 0, 8'h80, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 0, 8'h12, 1, 8'h80, 1, 8'h12, 1));
        tbl.push_back(mk(0, 1, 0, 8'h13, 1, 8'h80, 0, 8'h12, 1));
        tbl.push_back(mk(0, 1, 0, 8'h13, 0, 8'h12, 0, 8'h12, 1));
        tbl.push_back(mk(0, 1, 0, 8'h13, 0, 8'h12, 0, 8'h12, 1));
        tbl.push_back(mk(0, 0, 0, 8'h13, 0, 8'h80, 1, 8'h13, 0));
        tbl.push_back(mk(0, 0, 0, 8'h13, 0, 8'h80, 0, 8'h13, 0));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; en = tbl[i].en; mode = tbl[i].mode; ad = tbl[i].ad;
            step();
            chk_on = 1'b1;
            chk($sformatf("tbl%0d_adclk", i), 8'(adclk), 8'(tbl[i].adclk));
            chk($sformatf("tbl%0d_daclk", i), 8'(daclk), 8'(tbl[i].adclk));
            chk($sformatf("tbl%0d_da", i), da_data, tbl[i].da);
            chk($sformatf("tbl%0d_valid", i), 8'(sample_valid), 8'(tbl[i].valid));
            chk($sformatf("tbl%0d_sample", i), sample, tbl[i].sample);
            chk($sformatf("tbl%0d_busy", i), 8'(busy), 8'(tbl[i].busy));
            chk($sformatf("tbl%0d_ready", i), 8'(tx_ready), 8'h00);
        end

        // Idle hold: nothing moves for 50 cycles.
        for (int i = 0; i < 50; i++) begin
            step();
            chk("idle_quiet", {adclk, busy, sample_valid}, 8'h00);
        end

        // Stream with one missed slot, then simultaneous clear and underrun.
        rst = 1; step(); step();
        rst = 0; en = 1; mode = 2'd1; txv = 1; txd = 8'hA0;
        step(); chk("stream_ready_t0", 8'(tx_ready), 8'h00);
        step(); chk("stream_ready_t1", 8'(tx_ready), 8'h01);
        step(); chk("stream_da_a0", da_data, 8'hA0);
        chk("stream_und0", 8'(underrun), 8'h00);
        txd = 8'hA1;
        step(); step(); step(); chk("stream_ready_t5", 8'(tx_ready), 8'h01);
        step(); chk("stream_da_a1", da_data, 8'hA1);
        txv = 0;
        step(); step(); step();
        step(); chk("stream_hold_a1", da_data, 8'hA1);
        chk("stream_und_set", 8'(underrun), 8'h01);
        step(); step(); step(); chk("stream_und_sticky", 8'(underrun), 8'h01);
        clr = 1;
        step(); chk("stream_clr_vs_set", 8'(underrun), 8'h01);
        step(); chk("stream_clr", 8'(underrun), 8'h00);
        chk("stream_da_final", da_data, 8'hA1);
        clr = 0;

        // Mode switch mid-period takes effect only at the next update edge; then disable.
        mode = 2'd2; cst = 8'h33;
        goto_ph(1); step(); chk("mode2_da", da_data, 8'h33);
        mode = 2'd3;
        step(); step(); step(); chk("mode3_pending", da_data, 8'h33);
        step(); chk("mode3_applied", da_data, MID);
        goto_ph(1); en = 0;
        step(); chk("dis_busy_ph2", 8'(busy), 8'h01);
        step(); chk("dis_busy_ph3", 8'(busy), 8'h01);
        step(); chk("dis_idle_busy", 8'(busy), 8'h00);
        chk("dis_idle_clk", 8'(adclk), 8'h00);
        chk("dis_idle_da", da_data, MID);

        // Reset mid-RUN, then a full warm-up again.
        en = 1; mode = 2'd2; ad = 8'h77;
        for (int i = 0; i < 20; i++) step();
        goto_ph(2); rst = 1;
        step();
        chk("rst_run_outs", {adclk, daclk, sample_valid, tx_ready, underrun, busy}, 8'h00);
        chk("rst_run_da", da_data, MID);
        chk("rst_run_sample", sample, 8'h00);
        rst = 0;
        step();
        cnt = 0;
        while (!sample_valid && cnt < 40) begin
            step();
            cnt++;
        end
        chk("rewarm_latency", 8'(cnt), 8'(12));

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 59) == 0) en = ~en;
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
            cst = 8'($urandom);
            ad  = 8'($urandom);
            txd = 8'($urandom);
            txv = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 24) == 0);
            step();
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
